dds_channel_scheduler: RTL and testbench
========================================

DDS_CHANNEL_SCHEDULER -- requirements
Module: dds_channel_scheduler

Interface
REQ-001 SHALL provide parameter PHASE_DW, default 16: phase and tuning word width.
REQ-002 SHALL provide parameter NUM_CH, default 4 (range 2..16): number of time-multiplexed NCO channels; CH_W = max(1, clog2(NUM_CH)).
REQ-003 SHALL provide parameter DDS_LATENCY, default 4 (range 1..8): cycles from phase input to valid output of the downstream DDS.
REQ-004 SHALL provide port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL provide port reset_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL provide port cfg_wr_en, input, 1: configuration write strobe.
REQ-007 SHALL provide port cfg_ch, input, CH_W: target channel of the write.
REQ-008 SHALL provide port cfg_sel, input, 2: 00 = FTW, 01 = phase offset, 10 = clear accumulator, 11 = ignored.
REQ-009 SHALL provide port cfg_data, input, PHASE_DW: write data; ignored for clear.
REQ-010 SHALL provide port ch_enable, input, NUM_CH: per-channel enable, sampled every cycle.
REQ-011 SHALL provide port m_axis_phase_tdata, output, PHASE_DW: phase to the DDS.
REQ-012 SHALL provide port m_axis_phase_tvalid, output, 1: phase valid.
REQ-013 SHALL provide port m_axis_phase_tuser, output, CH_W: channel ID of the issued phase.
REQ-014 SHALL provide port out_ch_id, output, CH_W: channel ID aligned with the DDS output.
REQ-015 SHALL provide port out_ch_valid, output, 1: m_axis_phase_tvalid delayed by DDS_LATENCY cycles.

Function
REQ-016 SHALL hold per channel an FTW, an offset and an accumulator acc, each PHASE_DW bits unsigned.
REQ-017 SHALL select one slot channel per cycle; the selected channel is issued when its ch_enable bit is 1.
REQ-018 SHALL, on issue, register m_axis_phase_tdata = (acc + offset) mod 2^PHASE_DW, tvalid = 1 and tuser = channel, one cycle after selection.
REQ-019 SHALL, on issue, update acc <= (acc + FTW) mod 2^PHASE_DW; the output uses the pre-add acc.
REQ-020 SHALL hold acc of disabled or unselected channels; on re-enable the channel resumes from the held value.
REQ-021 SHALL apply a cfg write at the clock edge; a write in the cycle the target channel issues affects the output and the accumulate only from the next issue of that channel.
REQ-022 SHALL, for a clear coinciding with an issue of the same channel, output the pre-clear phase and leave acc = 0 (clear wins over accumulate).
REQ-023 SHALL drive m_axis_phase_tvalid = 0 with tdata and tuser holding their last values when no channel is issued.
REQ-024 SHALL shift {tvalid, tuser} through a DDS_LATENCY-deep register pipeline to produce out_ch_valid and out_ch_id.

Reset
REQ-025 SHALL, while reset_n = 0 at a clock edge, clear all FTW, offset and acc registers, the slot pointer and the tag pipeline, and drive every output to 0.
REQ-026 SHALL abandon an in-flight issue when reset is asserted; the first selection after release is channel 0, or in skip-idle mode the lowest enabled channel.

Configuration
REQ-027 SHALL, with macro DDS_SCHED_SKIP_IDLE_EN defined, select each cycle the next enabled channel in round-robin order after the last issued channel, so that tvalid = 1 whenever any channel is enabled.
REQ-028 SHALL, without DDS_SCHED_SKIP_IDLE_EN, use fixed TDM: the slot pointer increments 0..NUM_CH-1 and wraps every cycle regardless of enables, and disabled slots give tvalid = 0.
REQ-029 SHALL, in both modes, give tvalid = 0 when ch_enable = 0.

Verification (NUM_CH=4, PHASE_DW=16, DDS_LATENCY=4)
REQ-030 SHALL cover fixed-TDM issue: all channels enabled, ch0 FTW=0x0100 -> ch0 phases 0x0000, 0x0100, 0x0200 on every 4th cycle with tuser=0.
REQ-031 SHALL cover wrap-around: FTW=0x8000, offset=0x4000 -> phases 0x4000, 0xC000, 0x4000.
REQ-032 SHALL cover disabled channels: ch_enable=4'b0101 -> fixed TDM gives tvalid 1,0,1,0 with tuser 0,-,2,-; skip-idle gives tvalid always 1 with tuser 0,2,0,2.
REQ-033 SHALL cover simultaneous clear and issue: ch0 acc=0x0300, FTW=0x0100 -> output 0x0300 on that cycle and 0x0000 at the next ch0 issue.
REQ-034 SHALL cover tag alignment: an issue on ch3 at cycle N -> out_ch_valid=1 and out_ch_id=3 at cycle N+4.
REQ-035 SHALL cover reset mid-stream: reset_n low for 1 cycle -> all outputs 0, accumulators 0, and the first issue after release is ch0 with phase = offset 0x0000.

Source files
------------

// File: rtl/dds_channel_scheduler.sv
// DDS channel scheduler: time-multiplexes NUM_CH phase accumulators onto one DDS phase stream.
// Define DDS_SCHED_SKIP_IDLE_EN to visit only enabled channels (round-robin) instead of fixed TDM.
module dds_channel_scheduler #(
   parameter int  PHASE_DW    = 16,
   parameter int  NUM_CH      = 4,
   parameter int  DDS_LATENCY = 4,
   localparam int CH_W        = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cfg_wr_en,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_sel,
   input  logic [PHASE_DW-1:0] cfg_data,
   input  logic [NUM_CH-1:0]   ch_enable,
   output logic [PHASE_DW-1:0] m_axis_phase_tdata,
   output logic                m_axis_phase_tvalid,
   output logic [CH_W-1:0]     m_axis_phase_tuser,
   output logic [CH_W-1:0]     out_ch_id,
   output logic                out_ch_valid
);

   localparam logic [CH_W-1:0] SLOT_LAST = CH_W'(NUM_CH - 1);

   logic [PHASE_DW-1:0]    ftw_q [NUM_CH];
   logic [PHASE_DW-1:0]    off_q [NUM_CH];
   logic [PHASE_DW-1:0]    acc_q [NUM_CH];
   logic [CH_W-1:0]        slot_q, slot_d;
   logic [CH_W-1:0]        sel;
   logic                   issue;
   logic [PHASE_DW-1:0]    tdata_q;
   logic                   tvalid_q;
   logic [CH_W-1:0]        tuser_q;
   logic [DDS_LATENCY-1:0] vpipe_q;
   logic [CH_W-1:0]        idpipe_q [DDS_LATENCY];

`ifdef DDS_SCHED_SKIP_IDLE_EN
   // slot_q is the last issued channel; resetting it to the top makes the search start at ch0.
   localparam logic [CH_W-1:0] SLOT_RST = SLOT_LAST;

   always_comb begin
      logic [CH_W-1:0] idx;
      idx   = '0;
      sel   = slot_q;
      issue = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = CH_W'((int'(slot_q) + k) % NUM_CH);
         if (!issue && ch_enable[idx]) begin
            issue = 1'b1;
            sel   = idx;
         end
      end
      slot_d = issue ? sel : slot_q;
   end
`else
   localparam logic [CH_W-1:0] SLOT_RST = '0;

   always_comb begin
      sel    = slot_q;
      issue  = ch_enable[slot_q];
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + CH_W'(1);
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            ftw_q[i] <= '0;
            off_q[i] <= '0;
            acc_q[i] <= '0;
         end
         slot_q   <= SLOT_RST;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tuser_q  <= '0;
         vpipe_q  <= '0;
         for (int i = 0; i < DDS_LATENCY; i++) begin
            idpipe_q[i] <= '0;
         end
      end else begin
         slot_q   <= slot_d;
         tvalid_q <= issue;
         if (issue) begin
            tdata_q    <= acc_q[sel] + off_q[sel];
            tuser_q    <= sel;
            acc_q[sel] <= acc_q[sel] + ftw_q[sel];
         end
         // Placed after the accumulate so a clear on the issuing channel wins.
         if (cfg_wr_en && (int'(cfg_ch) < NUM_CH)) begin
            case (cfg_sel)
               2'b00:   ftw_q[cfg_ch] <= cfg_data;
               2'b01:   off_q[cfg_ch] <= cfg_data;
               2'b10:   acc_q[cfg_ch] <= '0;
               default: ;
            endcase
         end
         vpipe_q[0]  <= tvalid_q;
         idpipe_q[0] <= tuser_q;
         for (int i = 1; i < DDS_LATENCY; i++) begin
            vpipe_q[i]  <= vpipe_q[i-1];
            idpipe_q[i] <= idpipe_q[i-1];
         end
      end
   end

   assign m_axis_phase_tdata  = tdata_q;
   assign m_axis_phase_tvalid = tvalid_q;
   assign m_axis_phase_tuser  = tuser_q;
   assign out_ch_valid        = vpipe_q[DDS_LATENCY-1];
   assign out_ch_id           = idpipe_q[DDS_LATENCY-1];

endmodule

// File: tb/tb_dds_channel_scheduler.sv
// Bench for dds_channel_scheduler: directed scenarios plus randomized traffic against a
// per-cycle behavioural model; honours DDS_SCHED_SKIP_IDLE_EN like the design.
module tb_dds_channel_scheduler;

   localparam int PHASE_DW = 16;
   localparam int NUM_CH   = 4;
   localparam int LAT      = 4;
   localparam int CH_W     = 2;
`ifdef DDS_SCHED_SKIP_IDLE_EN
   localparam int PER = 1;
`else
   localparam int PER = NUM_CH;
`endif

   logic                clk = 1'b0;
   logic                reset_n;
   logic                cfg_wr_en;
   logic [CH_W-1:0]     cfg_ch;
   logic [1:0]          cfg_sel;
   logic [PHASE_DW-1:0] cfg_data;
   logic [NUM_CH-1:0]   ch_enable;
   logic [PHASE_DW-1:0] m_axis_phase_tdata;
   logic                m_axis_phase_tvalid;
   logic [CH_W-1:0]     m_axis_phase_tuser;
   logic [CH_W-1:0]     out_ch_id;
   logic                out_ch_valid;

   int total = 0;
   int bad   = 0;

   dds_channel_scheduler #(
      .PHASE_DW   (PHASE_DW),
      .NUM_CH     (NUM_CH),
      .DDS_LATENCY(LAT)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .cfg_wr_en          (cfg_wr_en),
      .cfg_ch             (cfg_ch),
      .cfg_sel            (cfg_sel),
      .cfg_data           (cfg_data),
      .ch_enable          (ch_enable),
      .m_axis_phase_tdata (m_axis_phase_tdata),
      .m_axis_phase_tvalid(m_axis_phase_tvalid),
      .m_axis_phase_tuser (m_axis_phase_tuser),
      .out_ch_id          (out_ch_id),
      .out_ch_valid       (out_ch_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [PHASE_DW-1:0] m_ftw [NUM_CH];
   logic [PHASE_DW-1:0] m_off [NUM_CH];
   logic [PHASE_DW-1:0] m_acc [NUM_CH];
   logic [PHASE_DW-1:0] m_tdata;
   logic                m_tvalid;
   logic [CH_W-1:0]     m_tuser;
   bit                  hv[$];
   logic [CH_W-1:0]     hid[$];
   int                  m_cyc;
   int                  m_last;
   int                  m_ch;
   int                  m_c;
   bit                  m_live = 1'b0;

   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_ftw[i] = '0;
            m_off[i] = '0;
            m_acc[i] = '0;
         end
         m_tdata  = '0;
         m_tvalid = 1'b0;
         m_tuser  = '0;
         m_cyc    = 0;
         m_last   = NUM_CH - 1;
         hv.delete();
         hid.delete();
         for (int i = 0; i < LAT; i++) begin
            hv.push_back(1'b0);
            hid.push_back('0);
         end
         m_live = 1'b1;
      end else begin
         hv.push_front(m_tvalid);
         hid.push_front(m_tuser);
         void'(hv.pop_back());
         void'(hid.pop_back());
         m_ch = -1;
`ifdef DDS_SCHED_SKIP_IDLE_EN
         for (int k = 1; k <= NUM_CH; k++) begin
            m_c = (m_last + k) % NUM_CH;
            if (m_ch < 0 && ch_enable[m_c[CH_W-1:0]]) m_ch = m_c;
         end
         if (m_ch >= 0) m_last = m_ch;
`else
         m_c = m_cyc % NUM_CH;
         if (ch_enable[m_c[CH_W-1:0]]) m_ch = m_c;
         m_cyc++;
`endif
         m_tvalid = (m_ch >= 0);
         if (m_ch >= 0) begin
            m_tdata     = m_acc[m_ch] + m_off[m_ch];
            m_tuser     = m_ch[CH_W-1:0];
            m_acc[m_ch] = m_acc[m_ch] + m_ftw[m_ch];
         end
         if (cfg_wr_en) begin
            case (cfg_sel)
               2'b00:   m_ftw[cfg_ch] = cfg_data;
               2'b01:   m_off[cfg_ch] = cfg_data;
               2'b10:   m_acc[cfg_ch] = '0;
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("tdata", 32'(m_axis_phase_tdata), 32'(m_tdata));
         chk("tvalid", 32'(m_axis_phase_tvalid), 32'(m_tvalid));
         chk("tuser", 32'(m_axis_phase_tuser), 32'(m_tuser));
         chk("out_ch_valid", 32'(out_ch_valid), 32'(hv[LAT-1]));
         chk("out_ch_id", 32'(out_ch_id), 32'(hid[LAT-1]));
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [PHASE_DW-1:0] cap [3];

   task automatic cfg_write(input int ch, input int sel, input logic [PHASE_DW-1:0] d);
      cfg_wr_en = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_sel   = 2'(sel);
      cfg_data  = d;
      @(negedge clk);
      cfg_wr_en = 1'b0;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      ch_enable = '0;
      cfg_wr_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic collect(input int ch, input int n);
      int got = 0;
      for (int cyc = 0; cyc < 64 && got < n; cyc++) begin
         @(negedge clk);
         if (m_axis_phase_tvalid && int'(m_axis_phase_tuser) == ch) begin
            cap[got] = m_axis_phase_tdata;
            got++;
         end
      end
      chk("collect_count", 32'(got), 32'(n));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]      exp_v;
      logic [CH_W-1:0] exp_u [4];
      bit              found;

      reset_n = 1'b0; cfg_wr_en = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
      ch_enable = '0;
      repeat (2) @(negedge clk);
      chk("rst_tdata", 32'(m_axis_phase_tdata), 32'h0);
      chk("rst_tvalid", 32'(m_axis_phase_tvalid), 32'h0);
      chk("rst_out_valid", 32'(out_ch_valid), 32'h0);

      // ch0 FTW=0x0100 -> 0x0000, 0x0100, 0x0200
      reset_n = 1'b1;
      cfg_write(0, 0, 16'h0100);
      ch_enable = 4'hF;
      collect(0, 3);
      chk("ftw_p0", 32'(cap[0]), 32'h0000);
      chk("ftw_p1", 32'(cap[1]), 32'h0100);
      chk("ftw_p2", 32'(cap[2]), 32'h0200);

      // wrap-around with offset
      do_reset();
      reset_n = 1'b1;
      cfg_write(1, 0, 16'h8000);
      cfg_write(1, 1, 16'h4000);
      ch_enable = 4'hF;
      collect(1, 3);
      chk("wrap_p0", 32'(cap[0]), 32'h4000);
      chk("wrap_p1", 32'(cap[1]), 32'hC000);
      chk("wrap_p2", 32'(cap[2]), 32'h4000);

      // disabled channels 4'b0101
`ifdef DDS_SCHED_SKIP_IDLE_EN
      exp_v = 4'b1111;
      exp_u[0] = 2'd0; exp_u[1] = 2'd2; exp_u[2] = 2'd0; exp_u[3] = 2'd2;
`else
      exp_v = 4'b0101;
      exp_u[0] = 2'd0; exp_u[1] = 2'd0; exp_u[2] = 2'd2; exp_u[3] = 2'd2;
`endif
      do_reset();
      reset_n   = 1'b1;
      ch_enable = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("dis_tvalid", 32'(m_axis_phase_tvalid), 32'(exp_v[i]));
         chk("dis_tuser", 32'(m_axis_phase_tuser), 32'(exp_u[i]));
      end

      // clear coinciding with an issue of ch0 whose acc is 0x0300
      do_reset();
      reset_n   = 1'b1;
      ch_enable = 4'b0001;
      cfg_wr_en = 1'b1; cfg_ch = '0; cfg_sel = 2'b00; cfg_data = 16'h0100;
      for (int k = 1; k <= 5 * PER; k++) begin
         @(negedge clk);
         cfg_wr_en = (k == 4 * PER);
         cfg_sel   = 2'b10;
         if (k - 1 == 4 * PER) begin
            chk("clr_valid", 32'(m_axis_phase_tvalid), 32'h1);
            chk("clr_pre", 32'(m_axis_phase_tdata), 32'h0300);
         end
      end
      @(negedge clk);
      chk("clr_post", 32'(m_axis_phase_tdata), 32'h0000);

      // tag alignment for ch3
      do_reset();
      reset_n   = 1'b1;
      ch_enable = 4'hF;
      found     = 1'b0;
      for (int i = 0; i < 32 && !found; i++) begin
         @(negedge clk);
         found = m_axis_phase_tvalid && (m_axis_phase_tuser == 2'd3);
      end
      chk("tag_found", 32'(found), 32'h1);
      repeat (LAT) @(negedge clk);
      chk("tag_valid", 32'(out_ch_valid), 32'h1);
      chk("tag_id", 32'(out_ch_id), 32'h3);

      // reset mid-stream
      cfg_write(0, 1, 16'h1234);
      cfg_write(0, 0, 16'h0040);
      repeat (6) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid_tdata", 32'(m_axis_phase_tdata), 32'h0);
      chk("mid_tvalid", 32'(m_axis_phase_tvalid), 32'h0);
      chk("mid_tuser", 32'(m_axis_phase_tuser), 32'h0);
      chk("mid_out_valid", 32'(out_ch_valid), 32'h0);
      chk("mid_out_id", 32'(out_ch_id), 32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("mid_first_valid", 32'(m_axis_phase_tvalid), 32'h1);
      chk("mid_first_user", 32'(m_axis_phase_tuser), 32'h0);
      chk("mid_first_data", 32'(m_axis_phase_tdata), 32'h0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset_n = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 3) == 0) ch_enable = NUM_CH'($urandom);
         cfg_wr_en = ($urandom_range(0, 2) == 0);
         cfg_ch    = CH_W'($urandom);
         cfg_sel   = 2'($urandom);
         cfg_data  = PHASE_DW'($urandom);
         @(negedge clk);
      end
      reset_n   = 1'b1;
      cfg_wr_en = 1'b0;
      repeat (8) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
